// File: rtl/hazard_ctrl_md.sv
//------------------------------------------------------------------------------
// hazard_ctrl_md : stall/forward controller for a 5-stage MIPS pipeline with a
// mult/div HI/LO interlock. Optional stall counter under HAZ_PERF_CNT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl_md #(
    parameter int REG_AW   = 5,
    parameter int T_W      = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int MD_CW    = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic [T_W-1:0]    d_tuse_rs,
    input  logic [T_W-1:0]    d_tuse_rt,
    input  logic              d_md_use,
    input  logic [REG_AW-1:0] e_rs,
    input  logic [REG_AW-1:0] e_rt,
    input  logic              e_use_rs,
    input  logic              e_use_rt,
    input  logic [REG_AW-1:0] m_rt,
    input  logic              m_use_rt,
    input  logic [REG_AW-1:0] e_dst,
    input  logic [REG_AW-1:0] m_dst,
    input  logic [REG_AW-1:0] w_dst,
    input  logic              e_we,
    input  logic              m_we,
    input  logic              w_we,
    input  logic [T_W-1:0]    e_tnew,
    input  logic [T_W-1:0]    m_tnew,
    input  logic              md_start,
    input  logic              md_is_div,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [MD_CW-1:0] MULT_LD = MD_CW'(MULT_CYC);
    localparam logic [MD_CW-1:0] DIV_LD  = MD_CW'(DIV_CYC);

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic hit(input logic we, input logic [REG_AW-1:0] dst,
                                 input logic [REG_AW-1:0] src);
        return we && (dst != '0) && (dst == src);
    endfunction

    function automatic logic dstall(input logic use_s, input logic [REG_AW-1:0] src,
                                    input logic [T_W-1:0] tuse);
        return use_s && ((hit(e_we, e_dst, src) && (tuse < e_tnew)) ||
                         (hit(m_we, m_dst, src) && (tuse < m_tnew)));
    endfunction

    function automatic logic [1:0] dfwd(input logic use_s, input logic [REG_AW-1:0] src,
                                        input logic [T_W-1:0] tuse);
        logic [1:0] sel;
        sel = 2'd0;
        if (use_s && (tuse == '0)) begin
            if (hit(e_we, e_dst, src))
                sel = (e_tnew == '0) ? 2'd1 : 2'd0;
            else if (hit(m_we, m_dst, src))
                sel = (m_tnew == '0) ? 2'd2 : 2'd0;
            else if (hit(w_we, w_dst, src))
                sel = 2'd3;
        end
        return sel;
    endfunction

    function automatic logic [1:0] efwd(input logic use_s, input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'd0;
        if (use_s) begin
            if (hit(m_we, m_dst, src) && (m_tnew == '0))
                sel = 2'd1;
            else if (hit(w_we, w_dst, src))
                sel = 2'd2;
        end
        return sel;
    endfunction

    logic [MD_CW-1:0] md_cnt;
    logic             data_stall;
    logic             md_stall;

    always_comb begin
        data_stall = dstall(d_use_rs, d_rs, d_tuse_rs) || dstall(d_use_rt, d_rt, d_tuse_rt);
        md_stall   = d_md_use && (md_busy || md_start);
        stall      = data_stall || md_stall;
        fwd_rs_d   = dfwd(d_use_rs, d_rs, d_tuse_rs);
        fwd_rt_d   = dfwd(d_use_rt, d_rt, d_tuse_rt);
        fwd_rs_e   = efwd(e_use_rs, e_rs);
        fwd_rt_e   = efwd(e_use_rt, e_rt);
        fwd_rt_m   = m_use_rt && hit(w_we, w_dst, m_rt);
    end

    // A new issue always reloads, so the most recent mult/div sets the interlock.
    always_ff @(posedge clk) begin
        if (!rst_n)
            md_cnt <= '0;
        else if (md_start)
            md_cnt <= md_is_div ? DIV_LD : MULT_LD;
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

    assign md_busy = (md_cnt != '0);

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (stall && !(&cnt_q))
            cnt_q <= cnt_q + 1'b1;
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire
